// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions for the fetch stage: branch-counter encodings, default
// parameters and the saturating-counter update rule.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr_e;

  localparam int unsigned DefaultAddrWidth  = 12;
  localparam int unsigned DefaultBtbEntries = 8;
  localparam int unsigned DefaultResetPc    = 0;

  // Two-bit saturating counter step towards the resolved outcome.
  function automatic ctr_e ctr_next(ctr_e ctr, logic taken);
    ctr_e res;
    unique case (ctr)
      CtrSnt:  res = taken ? CtrWnt : CtrSnt;
      CtrWnt:  res = taken ? CtrWt  : CtrSnt;
      CtrWt:   res = taken ? CtrSt  : CtrWnt;
      default: res = taken ? CtrSt  : CtrWt;
    endcase
    return res;
  endfunction

  function automatic logic ctr_predicts_taken(ctr_e ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect/stall control and branch resolution in, fetch PC and
// prediction out.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = fetch_unit_pkg::DefaultAddrWidth
);

  logic                  stall_f;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  br_valid;
  logic [ADDR_WIDTH-1:0] br_pc;
  logic                  br_taken;
  logic [ADDR_WIDTH-1:0] br_target;
  logic [ADDR_WIDTH-1:0] pc_f;
  logic [ADDR_WIDTH-1:0] pc_plus4_f;
  logic                  pred_taken_f;
  logic [ADDR_WIDTH-1:0] pred_target_f;

  // Core side: drives control and branch resolution, consumes the fetch address.
  modport master (
    output stall_f, redirect, redirect_pc, br_valid, br_pc, br_taken, br_target,
    input  pc_f, pc_plus4_f, pred_taken_f, pred_target_f
  );

  // Fetch unit side.
  modport slave (
    input  stall_f, redirect, redirect_pc, br_valid, br_pc, br_taken, br_target,
    output pc_f, pc_plus4_f, pred_taken_f, pred_target_f
  );

endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational lookup on the
// fetch PC, single-entry update per cycle from resolved branches.
module branch_target_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned AddrWidth = DefaultAddrWidth,
  parameter int unsigned Entries   = DefaultBtbEntries
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] lookup_pc_i,
  output logic                 pred_taken_o,
  output logic [AddrWidth-1:0] pred_target_o,
  input  logic                 upd_valid_i,
  input  logic [AddrWidth-1:0] upd_pc_i,
  input  logic                 upd_taken_i,
  input  logic [AddrWidth-1:0] upd_target_i
);

  localparam int unsigned IdxW = $clog2(Entries);
  localparam int unsigned TagW = AddrWidth - 2 - IdxW;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [TagW-1:0] tag_t;

  typedef struct packed {
    logic                 valid;
    tag_t                 tag;
    logic [AddrWidth-1:0] target;
    ctr_e                 ctr;
  } entry_t;

  localparam entry_t ResetEntry = '{valid: 1'b0, tag: '0, target: '0, ctr: CtrWnt};

  function automatic idx_t pc_index(logic [AddrWidth-1:0] pc);
    return pc[2 +: IdxW];
  endfunction

  function automatic tag_t pc_tag(logic [AddrWidth-1:0] pc);
    return pc[AddrWidth-1 -: TagW];
  endfunction

  entry_t entry_q [Entries];

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  idx_t   lk_idx;
  entry_t lk_entry;
  logic   lk_hit;

  always_comb begin
    lk_idx        = pc_index(lookup_pc_i);
    lk_entry      = entry_q[lk_idx];
    lk_hit        = lk_entry.valid && (lk_entry.tag == pc_tag(lookup_pc_i));
    pred_taken_o  = lk_hit && ctr_predicts_taken(lk_entry.ctr);
    pred_target_o = pred_taken_o ? lk_entry.target : '0;
  end

  idx_t   up_idx;
  tag_t   up_tag;
  entry_t up_entry;
  logic   up_hit;
  logic   wr_en;
  entry_t wr_entry;

  always_comb begin
    up_idx   = pc_index(upd_pc_i);
    up_tag   = pc_tag(upd_pc_i);
    up_entry = entry_q[up_idx];
    up_hit   = up_entry.valid && (up_entry.tag == up_tag);
    wr_en    = 1'b0;
    wr_entry = up_entry;
    if (upd_valid_i) begin
      if (up_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_next(up_entry.ctr, upd_taken_i);
        if (upd_taken_i) begin
          wr_entry.target = upd_target_i;
        end
      end else if (upd_taken_i) begin
        // Taken miss evicts whatever aliases into this slot.
        wr_en    = 1'b1;
        wr_entry = '{valid: 1'b1, tag: up_tag, target: upd_target_i, ctr: CtrWt};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Entries); i++) begin
        entry_q[i] <= ResetEntry;
      end
    end else if (wr_en) begin
      entry_q[up_idx] <= wr_entry;
    end
  end

  logic unused_pc_lo;
  assign unused_pc_lo = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC selection (redirect > stall > prediction > +4) and
// the branch target buffer that supplies predictions for the current PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = DefaultAddrWidth,
  parameter int unsigned           BTB_ENTRIES = DefaultBtbEntries,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DefaultResetPc)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fetch_unit_if.slave      bus_io
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;

  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

  branch_target_buffer #(
    .AddrWidth (ADDR_WIDTH),
    .Entries   (BTB_ENTRIES)
  ) u_btb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .lookup_pc_i   (pc_q),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_valid_i   (bus_io.br_valid),
    .upd_pc_i      (bus_io.br_pc),
    .upd_taken_i   (bus_io.br_taken),
    .upd_target_i  (bus_io.br_target)
  );

  // Redirect wins over stall: mispredict recovery must never be lost to a hold.
  always_comb begin
    pc_d = pc_plus4;
    if (bus_io.redirect) begin
      pc_d = bus_io.redirect_pc;
    end else if (bus_io.stall_f) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus_io.pc_f          = pc_q;
  assign bus_io.pc_plus4_f    = pc_plus4;
  assign bus_io.pred_taken_f  = pred_taken;
  assign bus_io.pred_target_f = pred_target;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: PC sequencing, BTB allocate/train/alias,
// redirect/stall priority, wrap and asynchronous reset.
module tb_fetch_unit;

  localparam int unsigned AW = 12;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_unit #(
    .ADDR_WIDTH  (AW),
    .BTB_ENTRIES (8),
    .RESET_PC    (12'h000)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall_f = 0; bus.redirect = 0; bus.redirect_pc = '0;
    bus.br_valid = 0; bus.br_pc = '0; bus.br_taken = 0; bus.br_target = '0;
    #12;
    n_tests++; if (bus.pc_f !== 12'h000) begin n_fail++;
      $display("FAIL reset_pc got %h exp %h", bus.pc_f, 12'h000); end
    n_tests++; if (bus.pc_plus4_f !== 12'h004) begin n_fail++;
      $display("FAIL reset_pc_plus4 got %h exp %h", bus.pc_plus4_f, 12'h004); end
    n_tests++; if (bus.pred_taken_f !== 1'b0 || bus.pred_target_f !== 12'h000) begin n_fail++;
      $display("FAIL reset_pred got %b/%h exp 0/000", bus.pred_taken_f, bus.pred_target_f); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_sequential();
    logic [AW-1:0] exp;
    n_tests++; if (bus.pc_f !== 12'h000) begin n_fail++;
      $display("FAIL seq_pc0 got %h exp %h", bus.pc_f, 12'h000); end
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = AW'(i * 4);
      n_tests++; if (bus.pc_f !== exp || bus.pred_taken_f !== 1'b0) begin n_fail++;
        $display("FAIL seq_pc%0d got %h/%b exp %h/0", i, bus.pc_f, bus.pred_taken_f, exp); end
    end
  endtask

  task automatic test_btb_alloc();
    bus.br_valid = 1; bus.br_pc = 12'h008; bus.br_taken = 1; bus.br_target = 12'h020;
    step();
    bus.br_valid = 0;
    bus.redirect = 1; bus.redirect_pc = 12'h008;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pred_taken_f !== 1'b1 || bus.pred_target_f !== 12'h020) begin n_fail++;
      $display("FAIL alloc_pred got %b/%h exp 1/020", bus.pred_taken_f, bus.pred_target_f); end
    step();
    n_tests++; if (bus.pc_f !== 12'h020) begin n_fail++;
      $display("FAIL alloc_follow got %h exp %h", bus.pc_f, 12'h020); end
  endtask

  task automatic test_train();
    // WT -> WNT -> SNT
    bus.br_valid = 1; bus.br_pc = 12'h008; bus.br_taken = 0; bus.br_target = 12'h000;
    step();
    step();
    bus.br_valid = 0;
    bus.redirect = 1; bus.redirect_pc = 12'h008;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pc_f !== 12'h008 || bus.pred_taken_f !== 1'b0 ||
                   bus.pred_target_f !== 12'h000) begin n_fail++;
      $display("FAIL nt_pred got %h/%b/%h exp 008/0/000", bus.pc_f, bus.pred_taken_f,
               bus.pred_target_f); end
    step();
    n_tests++; if (bus.pc_f !== 12'h00c) begin n_fail++;
      $display("FAIL nt_follow got %h exp %h", bus.pc_f, 12'h00c); end
    // SNT -> WNT: still not predicted
    bus.br_valid = 1; bus.br_taken = 1; bus.br_target = 12'h030;
    step();
    bus.br_valid = 0;
    bus.redirect = 1; bus.redirect_pc = 12'h008;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pred_taken_f !== 1'b0) begin n_fail++;
      $display("FAIL wnt_pred got %b exp 0", bus.pred_taken_f); end
    // WNT -> WT with rewritten target
    bus.br_valid = 1;
    step();
    bus.br_valid = 0;
    bus.redirect = 1;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pred_taken_f !== 1'b1 || bus.pred_target_f !== 12'h030) begin n_fail++;
      $display("FAIL wt_pred got %b/%h exp 1/030", bus.pred_taken_f, bus.pred_target_f); end
    step();
    n_tests++; if (bus.pc_f !== 12'h030) begin n_fail++;
      $display("FAIL wt_follow got %h exp %h", bus.pc_f, 12'h030); end
  endtask

  task automatic test_stall_redirect();
    bus.stall_f = 1; bus.redirect = 1; bus.redirect_pc = 12'h040;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pc_f !== 12'h040) begin n_fail++;
      $display("FAIL redirect_over_stall got %h exp %h", bus.pc_f, 12'h040); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus.pc_f !== 12'h040) begin n_fail++;
        $display("FAIL stall_hold%0d got %h exp %h", i, bus.pc_f, 12'h040); end
    end
    bus.stall_f = 0;
    step();
    n_tests++; if (bus.pc_f !== 12'h044) begin n_fail++;
      $display("FAIL stall_release got %h exp %h", bus.pc_f, 12'h044); end
  endtask

  task automatic test_wrap_alias();
    bus.redirect = 1; bus.redirect_pc = 12'hffc;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pc_plus4_f !== 12'h000 || bus.pred_taken_f !== 1'b0) begin n_fail++;
      $display("FAIL wrap_plus4 got %h/%b exp 000/0", bus.pc_plus4_f, bus.pred_taken_f); end
    step();
    n_tests++; if (bus.pc_f !== 12'h000) begin n_fail++;
      $display("FAIL wrap_pc got %h exp %h", bus.pc_f, 12'h000); end
    // 0x028 shares index 2 with 0x008 under a different tag
    bus.br_valid = 1; bus.br_pc = 12'h028; bus.br_taken = 1; bus.br_target = 12'h100;
    step();
    bus.br_valid = 0;
    bus.redirect = 1; bus.redirect_pc = 12'h008;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pred_taken_f !== 1'b0) begin n_fail++;
      $display("FAIL alias_evict got %b exp 0", bus.pred_taken_f); end
    step();
    n_tests++; if (bus.pc_f !== 12'h00c) begin n_fail++;
      $display("FAIL alias_follow got %h exp %h", bus.pc_f, 12'h00c); end
    bus.redirect = 1; bus.redirect_pc = 12'h028;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pred_taken_f !== 1'b1 || bus.pred_target_f !== 12'h100) begin n_fail++;
      $display("FAIL alias_new got %b/%h exp 1/100", bus.pred_taken_f, bus.pred_target_f); end
    step();
    n_tests++; if (bus.pc_f !== 12'h100) begin n_fail++;
      $display("FAIL alias_new_follow got %h exp %h", bus.pc_f, 12'h100); end
  endtask

  task automatic test_same_cycle();
    bus.redirect = 1; bus.redirect_pc = 12'h028;
    step();
    bus.redirect = 0;
    bus.br_valid = 1; bus.br_pc = 12'h028; bus.br_taken = 0; bus.br_target = 12'h000;
    step();
    bus.br_valid = 0;
    n_tests++; if (bus.pc_f !== 12'h100) begin n_fail++;
      $display("FAIL same_cycle_old got %h exp %h", bus.pc_f, 12'h100); end
    bus.redirect = 1;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pred_taken_f !== 1'b0) begin n_fail++;
      $display("FAIL same_cycle_new got %b exp 0", bus.pred_taken_f); end
  endtask

  task automatic test_reset_mid();
    bus.br_valid = 1; bus.br_pc = 12'h04c; bus.br_taken = 1; bus.br_target = 12'h200;
    step();
    bus.br_valid = 0;
    bus.redirect = 1; bus.redirect_pc = 12'h04c;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pred_taken_f !== 1'b1 || bus.pred_target_f !== 12'h200) begin n_fail++;
      $display("FAIL pre_reset_pred got %b/%h exp 1/200", bus.pred_taken_f, bus.pred_target_f); end
    bus.br_valid = 1; bus.br_pc = 12'h050; bus.br_taken = 1; bus.br_target = 12'h300;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.pc_f !== 12'h000 || bus.pred_taken_f !== 1'b0) begin n_fail++;
      $display("FAIL async_reset got %h/%b exp 000/0", bus.pc_f, bus.pred_taken_f); end
    step();
    @(negedge clk);
    bus.br_valid = 0;
    rst_n = 1'b1;
    step();
    n_tests++; if (bus.pc_f !== 12'h004) begin n_fail++;
      $display("FAIL first_advance got %h exp %h", bus.pc_f, 12'h004); end
    bus.redirect = 1; bus.redirect_pc = 12'h04c;
    step();
    n_tests++; if (bus.pred_taken_f !== 1'b0 || bus.pred_target_f !== 12'h000) begin n_fail++;
      $display("FAIL reset_cleared got %b/%h exp 0/000", bus.pred_taken_f, bus.pred_target_f); end
    bus.redirect_pc = 12'h050;
    step();
    bus.redirect = 0;
    n_tests++; if (bus.pc_f !== 12'h050 || bus.pred_taken_f !== 1'b0) begin n_fail++;
      $display("FAIL reset_drop_upd got %h/%b exp 050/0", bus.pc_f, bus.pred_taken_f); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_sequential();
    test_btb_alloc();
    test_train();
    test_stall_redirect();
    test_wrap_alias();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the byte-address width of every PC and target port.
REQ-002 Parameter BTB_ENTRIES, default 8 (power of two), SHALL set the branch-target-buffer depth.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 STALL_F  input  1  SHALL hold the PC when high.
REQ-007 REDIRECT  input  1  SHALL force the next PC to REDIRECT_PC (mispredict recovery from execute).
REQ-008 REDIRECT_PC  input  ADDR_WIDTH  SHALL carry the corrected fetch address.
REQ-009 BR_VALID  input  1  SHALL strobe one resolved branch for BTB update.
REQ-010 BR_PC  input  ADDR_WIDTH  SHALL carry the resolved branch address.
REQ-011 BR_TAKEN  input  1  SHALL carry the actual branch outcome.
REQ-012 BR_TARGET  input  ADDR_WIDTH  SHALL carry the actual branch target.
REQ-013 PC_F  output  ADDR_WIDTH  SHALL drive the instruction-memory ADDR port directly from the PC register.
REQ-014 PC_PLUS4_F  output  ADDR_WIDTH  SHALL equal PC_F+4 modulo 2^ADDR_WIDTH.
REQ-015 PRED_TAKEN_F  output  1  SHALL flag a taken prediction for the instruction at PC_F.
REQ-016 PRED_TARGET_F  output  ADDR_WIDTH  SHALL carry the predicted target, 0 when PRED_TAKEN_F is low.

Function
REQ-017 BTB SHALL be direct-mapped: index = PC[2 +: log2(BTB_ENTRIES)], tag = remaining upper PC bits above index; PC[1:0] ignored.
REQ-018 Each entry SHALL hold valid, tag, target, 2-bit saturating counter (SNT=00, WNT=01, WT=10, ST=11).
REQ-019 Lookup SHALL be combinational on PC_F: PRED_TAKEN_F = valid AND tag match AND counter[1].
REQ-020 Next-PC priority SHALL be: REDIRECT -> REDIRECT_PC; else STALL_F -> hold; else PRED_TAKEN_F -> PRED_TARGET_F; else PC_PLUS4_F.
REQ-021 REDIRECT SHALL override STALL_F when both are high.
REQ-022 PC increment SHALL wrap modulo 2^ADDR_WIDTH (0xFFC -> 0x000 at default width).
REQ-023 Update on BR_VALID with BR_PC hit: counter +1 saturating at ST if BR_TAKEN, -1 saturating at SNT otherwise; target rewritten with BR_TARGET when BR_TAKEN.
REQ-024 Update on BR_VALID with miss and BR_TAKEN: entry allocated (overwriting any occupant) with valid=1, new tag, BR_TARGET, counter=WT.
REQ-025 Update on BR_VALID with miss and not BR_TAKEN: no BTB change.
REQ-026 BTB update SHALL proceed regardless of STALL_F and REDIRECT.
REQ-027 Update and lookup to the same entry in one cycle: lookup SHALL use pre-update contents; new contents visible next cycle.
REQ-028 Fetch latency: PC_F SHALL take its next value one cycle after the selecting condition; prediction outputs valid the same cycle as PC_F.

Reset
REQ-029 RST_N low SHALL asynchronously set PC to RESET_PC, clear all valid bits, set all counters to WNT, tags/targets to 0.
REQ-030 After reset PC_F=RESET_PC, PC_PLUS4_F=RESET_PC+4, PRED_TAKEN_F=0, PRED_TARGET_F=0.
REQ-031 Reset asserted mid-operation SHALL discard any pending BR_VALID update in that cycle.
REQ-032 First PC advance SHALL occur on the first rising CLK edge after RST_N deasserts.

Structure
REQ-033 Counter encodings SNT/WNT/WT/ST and default RESET_PC SHALL live in the shared processor package.
REQ-034 BTB storage, lookup and update logic SHALL be one sub-module, branch_target_buffer; PC register and next-PC mux stay in fetch_unit.

Verification
REQ-035 Reset then 4 free cycles -> PC_F 0x000, 0x004, 0x008, 0x00C, 0x010; PRED_TAKEN_F=0 throughout.
REQ-036 BR_VALID, BR_PC=0x008, BR_TAKEN=1, BR_TARGET=0x020 -> next time PC_F=0x008: PRED_TAKEN_F=1, PRED_TARGET_F=0x020, following PC_F=0x020.
REQ-037 Two not-taken updates on 0x008 after REQ-036 -> counter WT->WNT->SNT; PC_F=0x008 then predicts not-taken, next PC_F=0x00C.
REQ-038 STALL_F=1 and REDIRECT=1 with REDIRECT_PC=0x040 same cycle -> next PC_F=0x040; STALL_F alone for 3 cycles -> PC_F held.
REQ-039 PC_F=0xFFC, no prediction -> next PC_F=0x000; BR_PC=0x028 taken aliasing index of 0x008 -> entry replaced, 0x008 no longer predicted.
REQ-040 RST_N pulsed low asynchronously mid-cycle with BR_VALID=1 -> PC_F=RESET_PC immediately, all entries invalid, no update retained.
